// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes, RV-style opcodes and ALU operation classes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_ADDI = 3'd2,
        CLS_LD   = 3'd3,
        CLS_SD   = 3'd4,
        CLS_BEQ  = 3'd5
    } iclass_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Signal bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             clear;
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             ALUSrc;
    logic             Branch;
    logic [1:0]       ALUOp;
    logic [2:0]       state;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, clear, opcode, zero, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg,
               ALUSrc, Branch, ALUOp, state, busy, illegal, timeout, retired
    );

    modport slave (
        output run, clear, opcode, zero, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg,
               ALUSrc, Branch, ALUOp, state, busy, illegal, timeout, retired
    );
endinterface

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier: instruction class plus a legal flag.
module opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_e    iclass,
    output logic       legal
);

    // Map the five supported opcodes; anything else is illegal
    always_comb begin
        iclass = CLS_NONE;
        legal  = 1'b0;
        case (opcode)
            OP_R:    begin iclass = CLS_R;    legal = 1'b1; end
            OP_ADDI: begin iclass = CLS_ADDI; legal = 1'b1; end
            OP_LD:   begin iclass = CLS_LD;   legal = 1'b1; end
            OP_SD:   begin iclass = CLS_SD;   legal = 1'b1; end
            OP_BEQ:  begin iclass = CLS_BEQ;  legal = 1'b1; end
            default: begin iclass = CLS_NONE; legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// wait timeout, illegal-opcode fault and a retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [6:0]        opc_q, opc_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc_s;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [6:0]        dec_opc_s;
    iclass_e           cls_s;
    logic              legal_s;
    logic              expired_s;
    logic              retire_s;
    logic              pc_write_s, ir_write_s, reg_write_s, mem_read_s;
    logic              mem_write_s, mem_to_reg_s, alu_src_s, branch_s;
    logic [1:0]        alu_op_s;

    // In DECODE the live opcode is judged; afterwards the latched copy rules
    assign dec_opc_s  = (state_q == ST_DECODE) ? bus.opcode : opc_q;
    assign wait_inc_s = wait_q + WAIT_W'(1);
    assign expired_s  = (wait_inc_s == WAIT_W'(MEM_TIMEOUT));

    opcode_decode u_dec (
        .opcode (dec_opc_s),
        .iclass (cls_s),
        .legal  (legal_s)
    );

    // Next-state, flag, counter and datapath-control decode
    always_comb begin
        state_d      = state_q;
        opc_d        = opc_q;
        wait_d       = '0;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        retired_d    = retired_q;
        retire_s     = 1'b0;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_s    = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = ALUOP_ADD;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
                else         state_d = ST_IDLE;
            end
            ST_FETCH: begin
                mem_read_s = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_DECODE;
                end else if (expired_s) begin
                    state_d   = ST_FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_DECODE: begin
                opc_d = bus.opcode;
                if (legal_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_FAULT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_R:    begin alu_op_s = ALUOP_FUNCT; state_d = ST_WB; end
                    CLS_ADDI: begin alu_src_s = 1'b1; state_d = ST_WB; end
                    CLS_LD,
                    CLS_SD:   begin alu_src_s = 1'b1; state_d = ST_MEM; end
                    CLS_BEQ: begin
                        alu_op_s   = ALUOP_SUB;
                        branch_s   = 1'b1;
                        pc_write_s = bus.zero;
                        retire_s   = 1'b1;
                    end
                    default: begin state_d = ST_FAULT; illegal_d = 1'b1; end
                endcase
            end
            ST_MEM: begin
                mem_read_s  = (cls_s == CLS_LD);
                mem_write_s = (cls_s == CLS_SD);
                if (bus.mem_ready) begin
                    if (cls_s == CLS_LD) state_d  = ST_WB;
                    else                 retire_s = 1'b1;
                end else if (expired_s) begin
                    state_d   = ST_FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (cls_s == CLS_LD);
                retire_s     = 1'b1;
            end
            ST_FAULT: begin
                if (bus.clear) begin
                    state_d   = ST_IDLE;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // run is only looked at here and in IDLE, so a drop mid-instruction lets it finish
        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = bus.run ? ST_FETCH : ST_IDLE;
        end else begin
            retired_d = retired_q;
        end
    end

    // FSM state, latched opcode, wait counter, sticky flags and retire count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opc_q     <= 7'd0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    assign bus.PCWrite  = pc_write_s;
    assign bus.IRWrite  = ir_write_s;
    assign bus.RegWrite = reg_write_s;
    assign bus.MemRead  = mem_read_s;
    assign bus.MemWrite = mem_write_s;
    assign bus.MemtoReg = mem_to_reg_s;
    assign bus.ALUSrc   = alu_src_s;
    assign bus.Branch   = branch_s;
    assign bus.ALUOp    = alu_op_s;
    assign bus.state    = state_q;
    assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign bus.illegal  = illegal_q;
    assign bus.timeout  = timeout_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle
// trace from the instruction rules, then replayed against the controller.
module tb_multicycle_control;

    localparam int CNT_W = 4;
    localparam int TMO   = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mr;
        logic [9:0] ctl;
    } step_t;

    int         total = 0;
    int         bad   = 0;
    int         ret_m = 0;
    step_t      plan[$];
    logic [6:0] ops [5];
    logic [9:0] ctl_obs;

    assign ctl_obs = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite,
                      bus.MemtoReg, bus.ALUSrc, bus.Branch, bus.ALUOp};

    function automatic logic [9:0] cv(input logic pcw, input logic irw, input logic rw,
                                      input logic mrd, input logic mwr, input logic m2r,
                                      input logic asrc, input logic br, input logic [1:0] aop);
        return {pcw, irw, rw, mrd, mwr, m2r, asrc, br, aop};
    endfunction

    function automatic step_t mk(input logic [2:0] st, input logic mr, input logic [9:0] ctl);
        step_t s;
        s.st = st; s.mr = mr; s.ctl = ctl;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a posedge with the controller in IDLE
    task automatic start();
        bus.run = 1'b1;
        @(negedge clk);
        chk("idle_state", bus.state, 3'd0);
        chk("idle_ctl", ctl_obs, 10'd0);
        chk("idle_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic recover(input logic exp_ill, input logic exp_tmo);
        bus.clear = 1'b0;
        @(negedge clk);
        chk("fault_ctl", ctl_obs, 10'd0);
        chk("fault_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        chk("fault_sticky", bus.state, 3'd6);
        chk("fault_ill", bus.illegal, exp_ill);
        chk("fault_tmo", bus.timeout, exp_tmo);
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        chk("clear_state", bus.state, 3'd0);
        chk("clear_ill", bus.illegal, 1'b0);
        chk("clear_tmo", bus.timeout, 1'b0);
        chk("clear_ret", bus.retired, ret_m);
    endtask

    // Called at #1 after a posedge with the controller in FETCH
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                             input logic run_after);
        int         kind;
        int         outcome;
        logic [9:0] ex_ctl;
        logic [9:0] mem_ctl;
        logic [2:0] endst;
        kind    = -1;
        outcome = 0;
        ex_ctl  = 10'd0;
        for (int i = 0; i < 5; i++) if (ops[i] == op) kind = i;
        plan.delete();
        for (int i = 0; i < fw && i < TMO; i++) plan.push_back(mk(3'd1, 1'b0, cv(0,0,0,1,0,0,0,0,2'b00)));
        if (fw >= TMO) outcome = 2;
        else begin
            plan.push_back(mk(3'd1, 1'b1, cv(1,1,0,1,0,0,0,0,2'b00)));
            plan.push_back(mk(3'd2, 1'b1, 10'd0));
            if (kind < 0) outcome = 1;
            else begin
                case (kind)
                    0:       ex_ctl = cv(0,0,0,0,0,0,0,0,2'b10);
                    4:       ex_ctl = cv(z,0,0,0,0,0,0,1,2'b01);
                    default: ex_ctl = cv(0,0,0,0,0,0,1,0,2'b00);
                endcase
                plan.push_back(mk(3'd3, 1'b1, ex_ctl));
                if (kind == 2 || kind == 3) begin
                    mem_ctl = (kind == 2) ? cv(0,0,0,1,0,0,0,0,2'b00) : cv(0,0,0,0,1,0,0,0,2'b00);
                    for (int i = 0; i < mw && i < TMO; i++) plan.push_back(mk(3'd4, 1'b0, mem_ctl));
                    if (mw >= TMO) outcome = 2;
                    else plan.push_back(mk(3'd4, 1'b1, mem_ctl));
                end
                if (outcome == 0 && kind <= 2)
                    plan.push_back(mk(3'd5, 1'b1, cv(0,0,1,0,0,(kind == 2),0,0,2'b00)));
            end
        end
        foreach (plan[k]) begin
            bus.mem_ready = plan[k].mr;
            bus.opcode    = (plan[k].st == 3'd2) ? op : 7'($urandom);
            bus.zero      = z;
            if (k == 0) bus.run = run_after;
            @(negedge clk);
            chk("state", bus.state, plan[k].st);
            chk("ctl", ctl_obs, plan[k].ctl);
            chk("busy", bus.busy, 1'b1);
            @(posedge clk); #1;
        end
        if (outcome == 0) begin
            ret_m = (ret_m + 1) % 16;
            endst = run_after ? 3'd1 : 3'd0;
        end else begin
            endst = 3'd6;
        end
        chk("end_state", bus.state, endst);
        chk("retired", bus.retired, ret_m);
        chk("illegal", bus.illegal, (outcome == 1));
        chk("timeout", bus.timeout, (outcome == 2));
        if (endst == 3'd6) begin
            recover(outcome == 1, outcome == 2);
            start();
        end else if (endst == 3'd0) begin
            start();
        end
    endtask

    initial begin
        int         r0;
        int         kk;
        logic [6:0] op;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;
        rst_n = 1'b0;
        bus.run = 1'b0; bus.clear = 1'b0; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", bus.state, 3'd0);
        chk("rst_ctl", ctl_obs, 10'd0);
        chk("rst_ret", bus.retired, 0);
        chk("rst_flags", {bus.busy, bus.illegal, bus.timeout}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_hold", bus.state, 3'd0);
        start();

        run_instr(ops[0], 1'b0, 0, 0, 1'b1);      // R-type
        run_instr(ops[2], 1'b0, 0, 3, 1'b1);      // ld with 3 MEM wait cycles
        run_instr(ops[4], 1'b1, 0, 0, 1'b1);      // beq taken
        run_instr(ops[4], 1'b0, 0, 0, 1'b1);      // beq not taken
        run_instr(7'b0000000, 1'b0, 0, 0, 1'b1);  // illegal opcode
        run_instr(ops[1], 1'b0, 15, 0, 1'b1);     // FETCH timeout
        run_instr(ops[1], 1'b0, 14, 0, 1'b1);     // ready on the 15th cycle
        run_instr(ops[3], 1'b0, 0, 15, 1'b1);     // MEM timeout
        run_instr(ops[2], 1'b1, 2, 14, 1'b1);
        run_instr(ops[1], 1'b0, 1, 0, 1'b0);      // run dropped mid-instruction

        r0 = ret_m;
        for (int i = 0; i < 16; i++) run_instr(ops[3], 1'b0, 0, 0, 1'b1);
        chk("wrap", bus.retired, r0);

        for (int i = 0; i < 30; i++) begin
            kk = $urandom_range(0, 5);
            if (kk == 5) begin
                op = 7'($urandom);
                for (int j = 0; j < 5; j++) if (ops[j] == op) op = 7'b1111111;
            end else begin
                op = ops[kk];
            end
            run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 3) != 0));
        end

        // Reset pulse while in EXEC of an sd
        bus.mem_ready = 1'b1;
        bus.opcode    = ops[3];
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_state", bus.state, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", bus.state, 3'd0);
        chk("arst_ctl", ctl_obs, 10'd0);
        chk("arst_ret", bus.retired, 0);
        chk("arst_flags", {bus.busy, bus.illegal, bus.timeout}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum cycles spent waiting for mem_ready before a fault.
REQ-003 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- run  in  1  enable instruction sequencing
- clear  in  1  leave FAULT
- opcode  in  7  instruction opcode from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch  out  1 each  datapath controls
- ALUOp  out  2  ALU operation class
- state  out  3  current FSM state
- busy  out  1  state not IDLE and not FAULT
- illegal  out  1  sticky: illegal opcode decoded
- timeout  out  1  sticky: memory wait exceeded
- retired  out  CNT_W  retired-instruction count

Function
REQ-005 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
REQ-006 IDLE: all controls 0; go to FETCH when run=1.
REQ-007 FETCH: MemRead=1; when mem_ready=1, IRWrite=1 and PCWrite=1 in that cycle; next state DECODE.
REQ-008 DECODE: opcode latched internally; the latched value drives all later states of this instruction.
- Legal opcodes: 0110011 (R), 0010011 (addi), 0000011 (ld), 0100011 (sd), 1100011 (beq).
- Legal: next EXEC; illegal: next FAULT, illegal set to 1.
REQ-009 EXEC:
- R: ALUOp=10, ALUSrc=0; next WB.
- addi: ALUOp=00, ALUSrc=1; next WB.
- ld/sd: ALUOp=00, ALUSrc=1; next MEM.
- beq: ALUOp=01, ALUSrc=0, Branch=1, PCWrite=zero; retire.
REQ-010 MEM:
- ld: MemRead=1; on mem_ready, next WB.
- sd: MemWrite=1; on mem_ready, retire.
REQ-011 WB: RegWrite=1 for one cycle; MemtoReg=1 only for ld; retire.
REQ-012 Retire: retired increments by 1 (mod 2^CNT_W, wraps to 0); next FETCH if run=1, else IDLE.
REQ-013 run deasserted mid-instruction: the current instruction completes; run is sampled only at retire and in IDLE.
REQ-014 Wait counter: cleared on entry to FETCH/MEM; increments each cycle mem_ready=0.
- On reaching MEM_TIMEOUT: next FAULT, timeout set to 1.
- If mem_ready=1 in the same cycle, mem_ready wins and no fault occurs.
REQ-015 FAULT: all controls 0; sticky until clear=1, then IDLE with illegal and timeout cleared; retired is preserved.
REQ-016 Latency with mem_ready held at 1: beq 3 cycles, R/addi/sd 4, ld 5 (FETCH to retire inclusive).
REQ-017 Controls decode combinationally from state, latched opcode, zero, and mem_ready; state, flags, and counters are registered.

Reset
REQ-018 rst_n=0 immediately forces:
- state IDLE; all control outputs, busy, illegal, timeout 0;
- retired 0; wait counter 0; latched opcode 0.
REQ-019 Reset asserted mid-instruction abandons that instruction without retiring it.

Structure
REQ-020 Shared package ctrl_pkg holds: opcode constants, state encoding, and ALUOp codes (00 add, 01 sub/compare, 10 funct-decoded).
REQ-021 One sub-module, opcode_decode: combinational; maps opcode to instruction class and a legal flag.

Verification
REQ-022 R-type, mem_ready=1, run=1: states 1,2,3,5; RegWrite=1 in cycle 4 only; retired 0->1.
REQ-023 ld with mem_ready low 3 cycles in MEM: MEM lasts 4 cycles; MemtoReg=1 and RegWrite=1 in WB; total 8 cycles.
REQ-024 beq, zero=1 then zero=0: PCWrite=1 in EXEC for the first, 0 for the second; Branch=1 in both.
REQ-025 opcode 0000000: DECODE->FAULT, illegal=1, retired unchanged; clear=1 -> IDLE, illegal=0.
REQ-026 mem_ready stuck 0 in FETCH: FAULT after 15 wait cycles with timeout=1; mem_ready=1 on cycle 15 -> no fault.
REQ-027 CNT_W=4, 16 sd instructions: retired wraps 15->0; rst_n pulse mid-EXEC -> all outputs 0 and state 0 immediately.
